// File: rtl/highlight_pkg.sv
// highlight_pkg: shared types and helpers for the highlight stream stage.
// Holds the per-frame mode encoding, the default highlight colour and the
// mode decoder that folds the reserved encoding onto replace.
package highlight_pkg;

  typedef enum logic [1:0] {
    MODE_REPLACE = 2'b00,
    MODE_BLEND   = 2'b01,
    MODE_PASS    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Widest pixel the default-colour helper can describe; callers truncate.
  localparam int MAX_PIX_W = 256;

  // Default highlight colour: channel 0 all ones, every other channel zero
  // (24'h0000ff for 8-bit RGB).
  function automatic logic [MAX_PIX_W-1:0] default_color(input int ch_w);
    logic [MAX_PIX_W-1:0] c;
    c = '0;
    for (int i = 0; i < ch_w; i++) begin
      c[i] = 1'b1;
    end
    return c;
  endfunction

  // Reserved encoding behaves as replace.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_BLEND;
      2'b10:   return MODE_PASS;
      default: return MODE_REPLACE;
    endcase
  endfunction

endpackage

// File: rtl/highlight_stream_if.sv
// highlight_stream_if: FIFO-side signals of the highlight stage.
// Input side: in_rd_en pops the colour/flag FIFO pair, in_empty is their OR'd empty.
// Output side: out_wr_en pushes out_din unless out_full; master = the stage, slave = FIFOs.
interface highlight_stream_if #(
  parameter int PIX_W = 24
);
  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] inC_dout;
  logic             inF_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  inC_dout,
    input  inF_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output inC_dout,
    output inF_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );
endinterface

// File: rtl/highlight_mix.sv
// highlight_mix: per-pixel transform (replace / blend / pass on motion pixels).
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: pix/flag in, mode/color config in, mix_pix out.
module highlight_mix
  import highlight_pkg::*;
#(
  parameter int CH_W     = 8,
  parameter int NUM_CH   = 3,
  parameter int PIX_W    = CH_W * NUM_CH,
  parameter bit FLAG_POL = 1'b0
) (
  input  logic [PIX_W-1:0] pix,
  input  logic             flag,
  input  mode_e            mode,
  input  logic [PIX_W-1:0] color,
  output logic [PIX_W-1:0] mix_pix
);

  logic             motion;
  logic [PIX_W-1:0] blend;

  assign motion = (flag == FLAG_POL);

  // Average per channel with one guard bit, so c + h never overflows.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CH_W:0] sum;
    assign sum = {1'b0, pix[g*CH_W +: CH_W]} + {1'b0, color[g*CH_W +: CH_W]};
    assign blend[g*CH_W +: CH_W] = CH_W'(sum >> 1);
  end

  always_comb begin
    mix_pix = pix;
    if (motion) begin
      case (mode)
        MODE_BLEND: mix_pix = blend;
        MODE_PASS:  mix_pix = pix;
        default:    mix_pix = color;
      endcase
    end
  end

endmodule

// File: rtl/highlight_stream.sv
// highlight_stream: highlight motion pixels of a FIFO-fed video stream, 1 pixel/cycle.
// Latency: a popped pixel appears on out_din the next cycle (single output register).
// Backpressure: pops only while the output register is empty or draining; holds data under out_full.
// Ports: clock/reset, bus (highlight_stream_if.master), cfg_mode/cfg_color,
// frame_done pulse and motion_count of the last frame.
// Optional macro HIGHLIGHT_STATS_EN enables per-frame motion statistics;
// without it frame_done and motion_count are tied to 0.
module highlight_stream
  import highlight_pkg::*;
#(
  parameter int CH_W         = 8,
  parameter int NUM_CH       = 3,
  parameter int PIX_W        = CH_W * NUM_CH,
  parameter int FRAME_PIXELS = 720 * 540,
  parameter bit FLAG_POL     = 1'b0,
  parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  highlight_stream_if.master bus,
  input  logic [1:0]         cfg_mode,
  input  logic [PIX_W-1:0]   cfg_color,
  output logic               frame_done,
  output logic [CNT_W-1:0]   motion_count
);

  localparam logic [PIX_W-1:0] DEF_COLOR = PIX_W'(default_color(CH_W));
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

  logic             valid_q;
  logic [PIX_W-1:0] data_q;
  logic [CNT_W-1:0] pix_cnt;
  mode_e            mode_q;
  logic [PIX_W-1:0] color_q;

  logic             pop;
  logic             push;
  logic             frame_start;
  logic             frame_last;
  mode_e            eff_mode;
  logic [PIX_W-1:0] eff_color;
  logic [PIX_W-1:0] mix_pix;

  assign pop         = ~bus.in_empty & (~valid_q | ~bus.out_full);
  assign push        = valid_q & ~bus.out_full;
  assign frame_start = (pix_cnt == '0);
  assign frame_last  = (pix_cnt == LAST_IDX);

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out_din   = data_q;

  // The first pixel of a frame already uses the config being latched with it.
  assign eff_mode  = frame_start ? decode_mode(cfg_mode) : mode_q;
  assign eff_color = frame_start ? cfg_color : color_q;

  highlight_mix #(
    .CH_W     (CH_W),
    .NUM_CH   (NUM_CH),
    .PIX_W    (PIX_W),
    .FLAG_POL (FLAG_POL)
  ) u_mix (
    .pix     (bus.inC_dout),
    .flag    (bus.inF_dout),
    .mode    (eff_mode),
    .color   (eff_color),
    .mix_pix (mix_pix)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pix_cnt <= '0;
      mode_q  <= MODE_REPLACE;
      color_q <= DEF_COLOR;
    end else begin
      if (pop) begin
        data_q  <= mix_pix;
        valid_q <= 1'b1;
        pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
        if (frame_start) begin
          mode_q  <= eff_mode;
          color_q <= cfg_color;
        end
      end else if (push) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef HIGHLIGHT_STATS_EN
  logic             motion;
  logic [CNT_W-1:0] motion_run;
  logic [CNT_W-1:0] motion_next;
  logic             frame_done_q;
  logic [CNT_W-1:0] motion_count_q;

  assign motion      = (bus.inF_dout == FLAG_POL);
  // Running count including the pixel popped this cycle.
  assign motion_next = motion_run + CNT_W'(motion);

  always_ff @(posedge clock) begin
    if (reset) begin
      motion_run     <= '0;
      frame_done_q   <= 1'b0;
      motion_count_q <= '0;
    end else begin
      frame_done_q <= pop & frame_last;
      if (pop) begin
        if (frame_last) begin
          motion_count_q <= motion_next;
          motion_run     <= '0;
        end else begin
          motion_run <= motion_next;
        end
      end
    end
  end

  assign frame_done   = frame_done_q;
  assign motion_count = motion_count_q;
`else
  assign frame_done   = 1'b0;
  assign motion_count = '0;
`endif

endmodule

// File: tb/tb_highlight_stream.sv
// tb_highlight_stream: directed checks of highlight_stream with a 4-pixel frame.
// Covers reset, replace/blend/pass, back-pressure, mid-frame config changes and reset mid-frame.
// Statistics expectations apply only when HIGHLIGHT_STATS_EN is defined.
module tb_highlight_stream;

`ifdef HIGHLIGHT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int PIX_W  = CH_W * NUM_CH;
  localparam int FRAME  = 4;
  localparam int CNT_W  = $clog2(FRAME + 1);

  logic             clock;
  logic             reset;
  logic [1:0]       cfg_mode;
  logic [PIX_W-1:0] cfg_color;
  logic             frame_done;
  logic [CNT_W-1:0] motion_count;

  int n_cmp;
  int n_err;

  highlight_stream_if #(.PIX_W(PIX_W)) bus ();

  highlight_stream #(
    .CH_W         (CH_W),
    .NUM_CH       (NUM_CH),
    .FRAME_PIXELS (FRAME),
    .FLAG_POL     (1'b0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .cfg_mode     (cfg_mode),
    .cfg_color    (cfg_color),
    .frame_done   (frame_done),
    .motion_count (motion_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pop one pixel with the output unblocked and check it one cycle later.
  task automatic send(input string tag, input logic [23:0] pix, input logic flag,
                      input logic [23:0] exp, input logic fd);
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    bus.inC_dout = pix;
    bus.inF_dout = flag;
    #1;
    chk({tag, "_rd_en"}, 32'(bus.in_rd_en), 32'd1);
    tick();
    chk({tag, "_wr_en"}, 32'(bus.out_wr_en), 32'd1);
    chk({tag, "_dout"}, 32'(bus.out_din), 32'(exp));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(fd & STATS));
  endtask

  // Stop feeding and let the register drain.
  task automatic idle();
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    tick();
    chk("idle_wr_en", 32'(bus.out_wr_en), 32'd0);
    chk("idle_frame_done", 32'(frame_done), 32'd0);
  endtask

  function automatic logic [23:0] bp_pix(input int i);
    return 24'h0a0b0c + 24'(i) * 24'h030201;
  endfunction

  initial begin
    logic vm;
    logic pe;
    logic pu;
    int   si;
    int   ri;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    cfg_mode = 2'b00;
    cfg_color = 24'h0000ff;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    bus.inC_dout = '0;
    bus.inF_dout = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
    chk("rst_dout", 32'(bus.out_din), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_motion_count", 32'(motion_count), 32'd0);
    chk("rst_rd_en_empty", 32'(bus.in_rd_en), 32'd0);

    // Replace frame: flags 0,1,0,1, back-to-back
    send("rep0", 24'h102030, 1'b0, 24'h0000ff, 1'b0);
    send("rep1", 24'h102030, 1'b1, 24'h102030, 1'b0);
    send("rep2", 24'h102030, 1'b0, 24'h0000ff, 1'b0);
    send("rep3", 24'h102030, 1'b1, 24'h102030, 1'b1);
    chk("rep_motion_count", 32'(motion_count), STATS ? 32'd2 : 32'd0);
    idle();

    // Blend frame with colour 000002; colour changes mid-frame are ignored
    cfg_mode = 2'b01;
    cfg_color = 24'h000002;
    send("bl0", 24'hfefefe, 1'b0, 24'h7f7f80, 1'b0);
    cfg_color = 24'hffffff;
    send("bl1", 24'h000000, 1'b1, 24'h000000, 1'b0);
    send("bl2", 24'h123456, 1'b1, 24'h123456, 1'b0);
    send("bl3", 24'h102030, 1'b0, 24'h081019, 1'b1);
    chk("bl_motion_count", 32'(motion_count), STATS ? 32'd2 : 32'd0);

    // Blend frame with colour ffffff (new frame picks it up), flags 0,0,1,0
    send("bw0", 24'hffffff, 1'b0, 24'hffffff, 1'b0);
    send("bw1", 24'h000000, 1'b0, 24'h7f7f7f, 1'b0);
    send("bw2", 24'h808080, 1'b1, 24'h808080, 1'b0);
    send("bw3", 24'h010101, 1'b0, 24'h808080, 1'b1);
    chk("bw_motion_count", 32'(motion_count), STATS ? 32'd3 : 32'd0);
    idle();

    // Back-pressure: 8 pixels (two frames, no motion) with out_full toggling
    cfg_mode = 2'b10;
    vm = 1'b0;
    si = 0;
    ri = 0;
    for (int cyc = 0; cyc < 40 && ri < 8; cyc++) begin
      bus.out_full = ((cyc % 2) == 1);
      bus.in_empty = (si >= 8);
      bus.inC_dout = bp_pix(si);
      bus.inF_dout = 1'b1;
      #1;
      pe = !bus.in_empty && (!vm || !bus.out_full);
      pu = vm && !bus.out_full;
      chk("bp_rd_en", 32'(bus.in_rd_en), 32'(pe));
      chk("bp_wr_en", 32'(bus.out_wr_en), 32'(pu));
      if (vm) chk("bp_dout", 32'(bus.out_din), 32'(bp_pix(ri)));
      if (pu) ri++;
      if (pe) begin
        vm = 1'b1;
        si++;
      end else if (pu) begin
        vm = 1'b0;
      end
      tick();
    end
    chk("bp_pushed", 32'(ri), 32'd8);
    chk("bp_popped", 32'(si), 32'd8);
    chk("bp_motion_count", 32'(motion_count), 32'd0);
    idle();

    // Mode change mid-frame: replace frame, switch to pass after pixel 1
    cfg_mode = 2'b00;
    cfg_color = 24'h0000ff;
    send("mc0", 24'h102030, 1'b0, 24'h0000ff, 1'b0);
    send("mc1", 24'h102030, 1'b0, 24'h0000ff, 1'b0);
    cfg_mode = 2'b10;
    cfg_color = 24'h00ff00;
    send("mc2", 24'h102030, 1'b0, 24'h0000ff, 1'b0);
    send("mc3", 24'h102030, 1'b0, 24'h0000ff, 1'b1);
    chk("mc_motion_count", 32'(motion_count), STATS ? 32'd4 : 32'd0);
    send("mc4", 24'h102030, 1'b0, 24'h102030, 1'b0);
    send("mc5", 24'h0a0b0c, 1'b1, 24'h0a0b0c, 1'b0);

    // Empty and full together: nothing moves, register holds
    bus.in_empty = 1'b1;
    bus.out_full = 1'b1;
    #1;
    chk("hold_rd_en", 32'(bus.in_rd_en), 32'd0);
    chk("hold_wr_en", 32'(bus.out_wr_en), 32'd0);
    tick();
    chk("hold_dout", 32'(bus.out_din), 32'h0a0b0c);
    chk("hold_wr_en2", 32'(bus.out_wr_en), 32'd0);

    // Reset mid-frame (valid=1, counter=2): held pixel discarded
    reset = 1'b1;
    bus.out_full = 1'b0;
    tick();
    reset = 1'b0;
    chk("mrst_wr_en", 32'(bus.out_wr_en), 32'd0);
    chk("mrst_dout", 32'(bus.out_din), 32'd0);
    chk("mrst_motion_count", 32'(motion_count), 32'd0);

    // First pop after reset starts a frame (latches blend) and fills despite out_full
    cfg_mode = 2'b01;
    cfg_color = 24'h000002;
    bus.out_full = 1'b1;
    bus.in_empty = 1'b0;
    bus.inC_dout = 24'hfefefe;
    bus.inF_dout = 1'b0;
    #1;
    chk("fill_rd_en", 32'(bus.in_rd_en), 32'd1);
    tick();
    bus.in_empty = 1'b1;
    #1;
    chk("fill_wr_en_full", 32'(bus.out_wr_en), 32'd0);
    chk("fill_dout", 32'(bus.out_din), 32'h7f7f80);
    bus.out_full = 1'b0;
    #1;
    chk("fill_wr_en", 32'(bus.out_wr_en), 32'd1);
    tick();
    chk("fill_drained", 32'(bus.out_wr_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
